mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline request/response and unified-memory bus signals for mem_port_arbiter.
// The master view belongs to the arbiter; the slave view belongs to pipeline plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic [DW-1:0]     if_rdata;
    logic              dm_req;
    logic              dm_wr;
    logic [DW/8-1:0]   dm_be;
    logic [AW-1:0]     dm_addr;
    logic [DW-1:0]     dm_wdata;
    logic [DW-1:0]     dm_rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_wr;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ack;
    logic              bus_err;

    modport master (
        input  if_req, if_addr, dm_req, dm_wr, dm_be, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, dm_rdata, stall, mem_req, mem_wr, mem_be, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_wr, dm_be, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, dm_rdata, stall, mem_req, mem_wr, mem_be, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data access, data first, stalling the
// pipeline until every access of the current pipeline cycle is done; includes an ack watchdog.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned   BW       = DW / 8;
    localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WDOG_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StData, StInst} state_e;

    state_e          r_state;
    logic            r_dm_done;
    logic            r_if_done;
    logic [CW-1:0]   r_wdog;
    logic            r_mem_req;
    logic            r_mem_wr;
    logic [BW-1:0]   r_mem_be;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_dm_rdata;
    logic            r_bus_err;

    logic            w_dm_pend;
    logic            w_if_pend;
    logic            w_stall;
    logic            w_timeout;
    logic            w_ack;
    logic            w_forced;
    logic [DW-1:0]   w_rdata;

    assign w_dm_pend = bus.dm_req & ~r_dm_done;
    assign w_if_pend = bus.if_req & ~r_if_done;
    assign w_stall   = w_dm_pend | w_if_pend;

    // A watchdog expiry completes the access as if acked, returning zero data.
    assign w_timeout = (r_state != StIdle) && (r_wdog == WDOG_MAX);
    assign w_ack     = bus.mem_ack | w_timeout;
    assign w_forced  = w_timeout & ~bus.mem_ack;
    assign w_rdata   = bus.mem_ack ? bus.mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_dm_done   <= 1'b0;
            r_if_done   <= 1'b0;
            r_wdog      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (!w_stall) begin
                r_dm_done <= 1'b0;
                r_if_done <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    r_wdog <= '0;
                    if (w_dm_pend) begin
                        r_state     <= StData;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= bus.dm_wr;
                        r_mem_be    <= bus.dm_wr ? bus.dm_be : '1;
                        r_mem_addr  <= bus.dm_addr;
                        r_mem_wdata <= bus.dm_wdata;
                    end else if (w_if_pend) begin
                        r_state     <= StInst;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= 1'b0;
                        r_mem_be    <= '1;
                        r_mem_addr  <= bus.if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                StData: begin
                    if (w_ack) begin
                        r_wdog    <= '0;
                        r_dm_done <= w_stall;
                        if (!r_mem_wr) r_dm_rdata <= w_rdata;
                        if (w_forced) r_bus_err <= 1'b1;
                        // Fetch follows immediately; mem_req may stay high across the switch.
                        if (w_if_pend) begin
                            r_state     <= StInst;
                            r_mem_wr    <= 1'b0;
                            r_mem_be    <= '1;
                            r_mem_addr  <= bus.if_addr;
                            r_mem_wdata <= '0;
                        end else begin
                            r_state   <= StIdle;
                            r_mem_req <= 1'b0;
                        end
                    end else begin
                        r_wdog <= r_wdog + CW'(1);
                    end
                end
                StInst: begin
                    if (w_ack) begin
                        r_wdog     <= '0;
                        r_if_done  <= w_stall;
                        r_if_rdata <= w_rdata;
                        if (w_forced) r_bus_err <= 1'b1;
                        r_state    <= StIdle;
                        r_mem_req  <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + CW'(1);
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_mem_req <= 1'b0;
                    r_wdog    <= '0;
                end
            endcase
        end
    end

    assign bus.stall     = w_stall;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.bus_err   = r_bus_err;
endmodule
